// File: rtl/sdram_port_arbiter_pkg.sv
// Shared types and helpers for the SDRAM port arbiter.
// Holds the FSM state encoding and refresh interval math.
package sdram_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_e;

    // Cycles between auto-refresh requests at the given clock rate.
    function automatic int refresh_cycles(input int freq, input int us);
        return freq / 1_000_000 * us;
    endfunction

    // Index width for a port count; never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sdram_rr_pick.sv
// Combinational round-robin picker.
// Returns the first requester at or after ptr, wrapping cyclically.
module sdram_rr_pick
    import sdram_port_arbiter_pkg::*;
#(
    parameter int N  = 2,
    parameter int IW = idx_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  onehot,
    output logic [IW-1:0] idx,
    output logic          any
);

    // Scan N slots starting at ptr and keep the first hit.
    always_comb begin
        onehot = '0;
        idx    = '0;
        any    = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!any && req[(int'(ptr) + i) % N]) begin
                any = 1'b1;
                idx = IW'((int'(ptr) + i) % N);
                onehot[(int'(ptr) + i) % N] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sdram_port_arbiter.sv
// N-port front end for the SDRAM controller.
// Round-robin client service with periodic auto-refresh that always wins.
module sdram_port_arbiter
    import sdram_port_arbiter_pkg::*;
#(
    parameter int NUM_PORTS  = 2,
    parameter int ADDR_W     = 23,
    parameter int DATA_W     = 32,
    parameter int FREQ       = 27_000_000,
    parameter int REFRESH_US = 15
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic [NUM_PORTS-1:0]        i_req,
    input  logic [NUM_PORTS-1:0]        i_we,
    input  logic [NUM_PORTS*ADDR_W-1:0] i_addr,
    input  logic [NUM_PORTS*DATA_W-1:0] i_wdata,
    output logic [NUM_PORTS-1:0]        o_gnt,
    output logic [NUM_PORTS-1:0]        o_done,
    output logic [DATA_W-1:0]           o_rdata,
    output logic                        o_sd_rd,
    output logic                        o_sd_wr,
    output logic                        o_sd_refresh,
    output logic [ADDR_W-1:0]           o_sd_addr,
    output logic [DATA_W-1:0]           o_sd_din,
    input  logic [DATA_W-1:0]           i_sd_dout,
    input  logic                        i_sd_busy,
    output logic                        o_refresh_late
);

    localparam int IW = idx_w(NUM_PORTS);
    localparam int RC = refresh_cycles(FREQ, REFRESH_US);
    localparam int CW = $clog2(RC + 1);

    state_e                state_q, state_d;
    logic [IW-1:0]         rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]         win_q, win_d;
    logic                  wr_op_q, wr_op_d;
    logic                  ref_op_q, ref_op_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  pend_q, pend_d;
    logic                  late_q, late_d;
    logic [NUM_PORTS-1:0]  gnt_q, gnt_d;
    logic [NUM_PORTS-1:0]  done_q, done_d;
    logic [DATA_W-1:0]     rdata_q, rdata_d;
    logic                  sd_rd_q, sd_rd_d;
    logic                  sd_wr_q, sd_wr_d;
    logic                  sd_ref_q, sd_ref_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [DATA_W-1:0]     din_q, din_d;

    logic [NUM_PORTS-1:0]  pick_onehot;
    logic [IW-1:0]         pick_idx;
    logic                  pick_any;
    logic                  wrap;
    logic                  pend_clr;
    logic [IW-1:0]         nxt_ptr;

    sdram_rr_pick #(
        .N  (NUM_PORTS),
        .IW (IW)
    ) u_pick (
        .req    (i_req),
        .ptr    (rr_ptr_q),
        .onehot (pick_onehot),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    // Next state: refresh timer, arbitration FSM and datapath latches.
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        win_d    = win_q;
        wr_op_d  = wr_op_q;
        ref_op_d = ref_op_q;
        gnt_d    = '0;
        done_d   = '0;
        rdata_d  = rdata_q;
        sd_rd_d  = sd_rd_q;
        sd_wr_d  = sd_wr_q;
        sd_ref_d = sd_ref_q;
        addr_d   = addr_q;
        din_d    = din_q;
        pend_clr = 1'b0;

        wrap    = (cnt_q == CW'(RC - 1));
        cnt_d   = wrap ? '0 : cnt_q + CW'(1);
        late_d  = late_q | (wrap & pend_q);
        nxt_ptr = (win_q == IW'(NUM_PORTS - 1)) ? '0 : win_q + IW'(1);

        unique case (state_q)
            ST_IDLE: begin
                if (!i_sd_busy) begin
                    if (pend_q) begin
                        sd_ref_d = 1'b1;
                        ref_op_d = 1'b1;
                        pend_clr = 1'b1;
                        state_d  = ST_ISSUE;
                    end else if (pick_any) begin
                        win_d    = pick_idx;
                        wr_op_d  = i_we[pick_idx];
                        ref_op_d = 1'b0;
                        addr_d   = i_addr[int'(pick_idx)*ADDR_W +: ADDR_W];
                        din_d    = i_wdata[int'(pick_idx)*DATA_W +: DATA_W];
                        gnt_d    = pick_onehot;
                        sd_wr_d  = i_we[pick_idx];
                        sd_rd_d  = !i_we[pick_idx];
                        state_d  = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                if (i_sd_busy) begin
                    sd_rd_d  = 1'b0;
                    sd_wr_d  = 1'b0;
                    sd_ref_d = 1'b0;
                    state_d  = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (!i_sd_busy) begin
                    state_d = ST_IDLE;
                    if (!ref_op_q) begin
                        done_d   = NUM_PORTS'(1) << win_q;
                        rr_ptr_d = nxt_ptr;
                        if (!wr_op_q) begin
                            rdata_d = i_sd_dout;
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A wrap in the same cycle as a refresh issue re-arms the request.
        pend_d = wrap ? 1'b1 : (pend_clr ? 1'b0 : pend_q);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= ST_IDLE;
            rr_ptr_q <= '0;
            win_q    <= '0;
            wr_op_q  <= 1'b0;
            ref_op_q <= 1'b0;
            cnt_q    <= '0;
            pend_q   <= 1'b0;
            late_q   <= 1'b0;
            gnt_q    <= '0;
            done_q   <= '0;
            rdata_q  <= '0;
            sd_rd_q  <= 1'b0;
            sd_wr_q  <= 1'b0;
            sd_ref_q <= 1'b0;
            addr_q   <= '0;
            din_q    <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            win_q    <= win_d;
            wr_op_q  <= wr_op_d;
            ref_op_q <= ref_op_d;
            cnt_q    <= cnt_d;
            pend_q   <= pend_d;
            late_q   <= late_d;
            gnt_q    <= gnt_d;
            done_q   <= done_d;
            rdata_q  <= rdata_d;
            sd_rd_q  <= sd_rd_d;
            sd_wr_q  <= sd_wr_d;
            sd_ref_q <= sd_ref_d;
            addr_q   <= addr_d;
            din_q    <= din_d;
        end
    end

    assign o_gnt          = gnt_q;
    assign o_done         = done_q;
    assign o_rdata        = rdata_q;
    assign o_sd_rd        = sd_rd_q;
    assign o_sd_wr        = sd_wr_q;
    assign o_sd_refresh   = sd_ref_q;
    assign o_sd_addr      = addr_q;
    assign o_sd_din       = din_q;
    assign o_refresh_late = late_q;

endmodule
